// File: rtl/binary_mac_acc.sv
// Saturating signed accumulate stage behind the 8x8 array multiplier: sums each
// group of N products into an AW-bit result presented on a valid/ready port.
module binary_mac_acc #(
  parameter int PW = 15,
  parameter int AW = 20,
  parameter int N  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic [PW-1:0] p_in,
  input  logic          p_valid,
  output logic          p_ready,
  output logic [AW-1:0] acc_out,
  output logic          acc_valid,
  input  logic          acc_ready,
  output logic          sat
);

  localparam int            CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Returns {clamped, value}: one guard bit detects overflow of the AW-bit range.
  function automatic logic [AW:0] sat_add(input logic [AW-1:0] a, input logic [PW-1:0] p);
    logic [AW:0] s;
    s = {a[AW-1], a} + {{(AW + 1 - PW){p[PW-1]}}, p};
    if (s[AW] == s[AW-1]) begin
      sat_add = {1'b0, s[AW-1:0]};
    end else if (s[AW] == 1'b0) begin
      sat_add = {1'b1, 1'b0, {(AW - 1){1'b1}}};
    end else begin
      sat_add = {1'b1, 1'b1, {(AW - 1){1'b0}}};
    end
  endfunction

  state_t        state_r, state_s;
  logic [AW-1:0] acc_r, acc_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          sat_run_r, sat_run_s;
  logic [AW-1:0] acc_out_r, acc_out_s;
  logic          acc_valid_r, acc_valid_s;
  logic          sat_r, sat_s;
  logic [AW:0]   sum_s;

  assign p_ready   = (state_r == ACC);
  assign acc_out   = acc_out_r;
  assign acc_valid = acc_valid_r;
  assign sat       = sat_r;

  // Next-state and datapath update; clear overrides every other action.
  always_comb begin
    sum_s       = sat_add(acc_r, p_in);
    state_s     = state_r;
    acc_s       = acc_r;
    cnt_s       = cnt_r;
    sat_run_s   = sat_run_r;
    acc_out_s   = acc_out_r;
    acc_valid_s = acc_valid_r;
    sat_s       = sat_r;
    if (clear) begin
      state_s     = ACC;
      acc_s       = '0;
      cnt_s       = '0;
      sat_run_s   = 1'b0;
      acc_valid_s = 1'b0;
      sat_s       = 1'b0;
    end else begin
      case (state_r)
        ACC: begin
          if (p_valid && p_ready) begin
            if (cnt_r == CNT_LAST) begin
              acc_out_s   = sum_s[AW-1:0];
              sat_s       = sat_run_r | sum_s[AW];
              acc_valid_s = 1'b1;
              acc_s       = '0;
              cnt_s       = '0;
              sat_run_s   = 1'b0;
              state_s     = HOLD;
            end else begin
              acc_s     = sum_s[AW-1:0];
              cnt_s     = cnt_r + CW'(1);
              sat_run_s = sat_run_r | sum_s[AW];
            end
          end else begin
            state_s = ACC;
          end
        end
        HOLD: begin
          if (acc_valid_r && acc_ready) begin
            acc_valid_s = 1'b0;
            state_s     = ACC;
          end else begin
            state_s = HOLD;
          end
        end
        default: begin
          state_s     = ACC;
          acc_s       = '0;
          cnt_s       = '0;
          sat_run_s   = 1'b0;
          acc_valid_s = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ACC;
      acc_r       <= '0;
      cnt_r       <= '0;
      sat_run_r   <= 1'b0;
      acc_out_r   <= '0;
      acc_valid_r <= 1'b0;
      sat_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      cnt_r       <= cnt_s;
      sat_run_r   <= sat_run_s;
      acc_out_r   <= acc_out_s;
      acc_valid_r <= acc_valid_s;
      sat_r       <= sat_s;
    end
  end

endmodule

// File: tb/tb_binary_mac_acc.sv
// Directed bench for binary_mac_acc: three instances (N4/AW20, N4/AW16, N8/AW20)
// share stimulus; the one selected by sel is checked.
module tb_binary_mac_acc;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic [14:0] p_in;
  logic        p_valid;
  logic        acc_ready;

  logic        p_ready0, acc_valid0, sat0;
  logic [19:0] acc_out0;
  logic        p_ready1, acc_valid1, sat1;
  logic [15:0] acc_out1;
  logic        p_ready2, acc_valid2, sat2;
  logic [19:0] acc_out2;

  int          sel;
  logic        cur_p_ready, cur_valid, cur_sat;
  logic signed [19:0] cur_out;

  int n_checks;
  int n_fail;

  binary_mac_acc #(.PW(15), .AW(20), .N(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .p_in(p_in), .p_valid(p_valid),
    .p_ready(p_ready0), .acc_out(acc_out0), .acc_valid(acc_valid0),
    .acc_ready(acc_ready), .sat(sat0)
  );

  binary_mac_acc #(.PW(15), .AW(16), .N(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .p_in(p_in), .p_valid(p_valid),
    .p_ready(p_ready1), .acc_out(acc_out1), .acc_valid(acc_valid1),
    .acc_ready(acc_ready), .sat(sat1)
  );

  binary_mac_acc #(.PW(15), .AW(20), .N(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .p_in(p_in), .p_valid(p_valid),
    .p_ready(p_ready2), .acc_out(acc_out2), .acc_valid(acc_valid2),
    .acc_ready(acc_ready), .sat(sat2)
  );

  always_comb begin
    case (sel)
      1: begin
        cur_p_ready = p_ready1;
        cur_valid   = acc_valid1;
        cur_sat     = sat1;
        cur_out     = {{4{acc_out1[15]}}, acc_out1};
      end
      2: begin
        cur_p_ready = p_ready2;
        cur_valid   = acc_valid2;
        cur_sat     = sat2;
        cur_out     = acc_out2;
      end
      default: begin
        cur_p_ready = p_ready0;
        cur_valid   = acc_valid0;
        cur_sat     = sat0;
        cur_out     = acc_out0;
      end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int sel;
    int p[4];
    int exp_out;
    int exp_sat;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    clear     = 1'b0;
    p_valid   = 1'b0;
    p_in      = 15'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic feed(input int v);
    p_in    = 15'(v);
    p_valid = 1'b1;
    step();
    p_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    p_valid = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    sel       = 0;
    acc_ready = 1'b1;
    do_reset();

    chk("reset_p_ready", int'(cur_p_ready), 1);
    chk("reset_acc_valid", int'(cur_valid), 0);
    chk("reset_acc_out", int'(cur_out), 0);
    chk("reset_sat", int'(cur_sat), 0);

    vecs[0] = '{sel: 0, p: '{100, -3, 16383, -16384},       exp_out: 96,     exp_sat: 0};
    vecs[1] = '{sel: 0, p: '{-16384, -16384, -16384, -16384}, exp_out: -65536, exp_sat: 0};
    vecs[2] = '{sel: 0, p: '{16383, -1, 0, 5},              exp_out: 16387,  exp_sat: 0};
    vecs[3] = '{sel: 1, p: '{16383, 16383, 16383, 16383},   exp_out: 32767,  exp_sat: 1};
    vecs[4] = '{sel: 1, p: '{1, 1, 1, 1},                   exp_out: 4,      exp_sat: 0};
    vecs[5] = '{sel: 1, p: '{-16384, -16384, -16384, 16383}, exp_out: -16385, exp_sat: 1};

    // Table of N=4 groups, acc_ready held high throughout.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].sel != sel) begin
        sel = vecs[i].sel;
        do_reset();
      end
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("v%0d_p_ready_%0d", i, k), int'(cur_p_ready), 1);
        p_in    = 15'(vecs[i].p[k]);
        p_valid = 1'b1;
        step();
        if (k < 3) chk($sformatf("v%0d_early_valid_%0d", i, k), int'(cur_valid), 0);
      end
      p_valid = 1'b0;
      chk($sformatf("v%0d_acc_valid", i), int'(cur_valid), 1);
      chk($sformatf("v%0d_acc_out", i), int'(cur_out), vecs[i].exp_out);
      chk($sformatf("v%0d_sat", i), int'(cur_sat), vecs[i].exp_sat);
      chk($sformatf("v%0d_hold_p_ready", i), int'(cur_p_ready), 0);
      step();
      chk($sformatf("v%0d_post_valid", i), int'(cur_valid), 0);
      chk($sformatf("v%0d_post_p_ready", i), int'(cur_p_ready), 1);
      chk($sformatf("v%0d_post_out", i), int'(cur_out), vecs[i].exp_out);
      chk($sformatf("v%0d_post_sat", i), int'(cur_sat), vecs[i].exp_sat);
    end

    // Clear after a saturated result: sat drops, acc_out is retained.
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_sat", int'(cur_sat), 0);
    chk("clear_out_kept", int'(cur_out), -16385);
    chk("clear_valid", int'(cur_valid), 0);

    // Backpressure: result held while acc_ready low, offered products ignored.
    sel = 0;
    do_reset();
    acc_ready = 1'b0;
    feed(10); feed(20); feed(30);
    p_in    = 15'd40;
    p_valid = 1'b1;
    step();
    p_in = 15'd999;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_valid_%0d", k), int'(cur_valid), 1);
      chk($sformatf("bp_out_%0d", k), int'(cur_out), 100);
      chk($sformatf("bp_p_ready_%0d", k), int'(cur_p_ready), 0);
      step();
    end
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
    chk("bp_release_valid", int'(cur_valid), 0);
    chk("bp_release_p_ready", int'(cur_p_ready), 1);
    p_in = 15'd1; step();
    p_in = 15'd2; step();
    p_in = 15'd3; step();
    p_in = 15'd4; step();
    p_valid = 1'b0;
    chk("bp_next_valid", int'(cur_valid), 1);
    chk("bp_next_out", int'(cur_out), 10);
    acc_ready = 1'b1;
    step();

    // Gaps in p_valid, clear mid-group, then a full N=8 group.
    sel = 2;
    do_reset();
    feed(5); idle(2); feed(5); idle(1); feed(5);
    chk("gap_no_result", int'(cur_valid), 0);
    p_in    = 15'd7;
    p_valid = 1'b1;
    clear   = 1'b1;
    step();
    clear   = 1'b0;
    p_valid = 1'b0;
    chk("clr_valid", int'(cur_valid), 0);
    chk("clr_p_ready", int'(cur_p_ready), 1);
    for (int k = 0; k < 8; k++) begin
      if (k == 3 || k == 6) idle(1);
      feed(2);
      if (k < 7) chk($sformatf("n8_early_valid_%0d", k), int'(cur_valid), 0);
    end
    chk("n8_valid", int'(cur_valid), 1);
    chk("n8_out", int'(cur_out), 16);
    chk("n8_sat", int'(cur_sat), 0);
    step();

    // Asynchronous reset while holding a saturated result.
    sel = 1;
    do_reset();
    acc_ready = 1'b0;
    feed(16383); feed(16383); feed(16383); feed(16383);
    chk("ar_pre_valid", int'(cur_valid), 1);
    chk("ar_pre_sat", int'(cur_sat), 1);
    chk("ar_pre_out", int'(cur_out), 32767);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_async_valid", int'(cur_valid), 0);
    chk("ar_async_out", int'(cur_out), 0);
    chk("ar_async_sat", int'(cur_sat), 0);
    step();
    rst_n     = 1'b1;
    acc_ready = 1'b1;
    chk("ar_p_ready", int'(cur_p_ready), 1);
    feed(1); feed(2); feed(3); feed(4);
    chk("ar_fresh_valid", int'(cur_valid), 1);
    chk("ar_fresh_out", int'(cur_out), 10);
    chk("ar_fresh_sat", int'(cur_sat), 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
